// File: rtl/vx_tb_mem_responder.sv
// vx_tb_mem_responder: memory model used as the slave end of the memory bus in the
// testbench. It stores full-line writes in a backing array and returns read
// responses, carrying the request tag, after a fixed latency. Responses pass
// through a credit-limited queue.
//
// Optional feature: define VX_TB_MEM_WRITE_ACK_EN so that accepted writes also
// produce a response (data 0, request tag) and consume a credit.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   req_valid/ready        request handshake (accept when both high at posedge)
//   req_rw                 1=write, 0=read
//   req_addr/data/tag      line address, write data, request tag
//   rsp_valid/ready        response handshake (consume when both high at posedge)
//   rsp_data/tag           read data and tag of the originating request
//   wr_count/rd_count      accepted writes/reads since reset (wrap at 2^32)
//
// The backing store has no reset and keeps its contents across reset. It starts
// at zero because the simulator's zero initial state is relied on.

module vx_tb_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 26,
    parameter int unsigned LINE_WIDTH  = 512,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned RSP_LATENCY = 4,
    parameter int unsigned RSPQ_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_rw,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  rsp_ready,
    output logic [31:0]           wr_count,
    output logic [31:0]           rd_count
);

    localparam int unsigned CW    = $clog2(RSPQ_DEPTH + 1);
    localparam int unsigned LINES = 1 << DEPTH_LOG2;

    logic [LINE_WIDTH-1:0] store [LINES];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  accept;
    logic                  gen;
    logic [LINE_WIDTH-1:0] gen_data;

    logic                  push;
    logic [LINE_WIDTH-1:0] push_data;
    logic [TAG_WIDTH-1:0]  push_tag;
    logic                  pop;

    logic [LINE_WIDTH-1:0] q_data   [RSPQ_DEPTH];
    logic [TAG_WIDTH-1:0]  q_tag    [RSPQ_DEPTH];
    logic [LINE_WIDTH-1:0] q_data_n [RSPQ_DEPTH];
    logic [TAG_WIDTH-1:0]  q_tag_n  [RSPQ_DEPTH];
    logic [CW-1:0]         q_cnt, q_cnt_n, wpos;
    logic [CW-1:0]         out_cnt, out_cnt_n;

    assign idx    = req_addr[DEPTH_LOG2-1:0];
    assign accept = req_valid && req_ready && !reset;
    assign pop    = rsp_valid && rsp_ready;

    // Upper address bits alias; they are intentionally ignored.
    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_alias
            logic unused_addr;
            assign unused_addr = &{1'b0, req_addr[ADDR_WIDTH-1:DEPTH_LOG2]};
        end
    endgenerate

    // Which accepts generate a response, and the data that response carries.
`ifdef VX_TB_MEM_WRITE_ACK_EN
    assign gen      = accept;
    assign gen_data = req_rw ? '0 : store[idx];
`else
    assign gen      = accept && !req_rw;
    assign gen_data = store[idx];
`endif

    // Backing store: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (accept && req_rw) begin
            store[idx] <= req_data;
        end
    end

    // Latency pipe: RSP_LATENCY-1 register stages feed the queue, so rsp_valid
    // rises RSP_LATENCY cycles after the accept cycle when the queue is empty.
    generate
        if (RSP_LATENCY > 1) begin : g_pipe
            localparam int NS = int'(RSP_LATENCY) - 1;
            logic [NS-1:0]         v;
            logic [LINE_WIDTH-1:0] d [NS];
            logic [TAG_WIDTH-1:0]  t [NS];

            always_ff @(posedge clk) begin
                if (reset) begin
                    v <= '0;
                end else begin
                    v[0] <= gen;
                    for (int i = 1; i < NS; i++) begin
                        v[i] <= v[i-1];
                    end
                end
                d[0] <= gen_data;
                t[0] <= req_tag;
                for (int i = 1; i < NS; i++) begin
                    d[i] <= d[i-1];
                    t[i] <= t[i-1];
                end
            end

            assign push      = v[NS-1];
            assign push_data = d[NS-1];
            assign push_tag  = t[NS-1];
        end else begin : g_nopipe
            assign push      = gen;
            assign push_data = gen_data;
            assign push_tag  = req_tag;
        end
    endgenerate

    // Queue next state: entry 0 is the head; pop shifts down, push fills the
    // first free slot after the pop.
    always_comb begin
        q_data_n = q_data;
        q_tag_n  = q_tag;
        wpos     = q_cnt - CW'(pop);
        if (pop) begin
            for (int i = 0; i < int'(RSPQ_DEPTH) - 1; i++) begin
                q_data_n[i] = q_data[i+1];
                q_tag_n[i]  = q_tag[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < int'(RSPQ_DEPTH); i++) begin
                if (CW'(i) == wpos) begin
                    q_data_n[i] = push_data;
                    q_tag_n[i]  = push_tag;
                end
            end
        end
        q_cnt_n   = q_cnt + CW'(push) - CW'(pop);
        out_cnt_n = out_cnt + CW'(gen) - CW'(pop);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(RSPQ_DEPTH); i++) begin
                q_data[i] <= '0;
                q_tag[i]  <= '0;
            end
            q_cnt     <= '0;
            out_cnt   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            q_data    <= q_data_n;
            q_tag     <= q_tag_n;
            q_cnt     <= q_cnt_n;
            out_cnt   <= out_cnt_n;
            req_ready <= (out_cnt_n < CW'(RSPQ_DEPTH));
            rsp_valid <= (q_cnt_n != '0);
            wr_count  <= wr_count + 32'(accept && req_rw);
            rd_count  <= rd_count + 32'(accept && !req_rw);
        end
    end

    assign rsp_data = q_data[0];
    assign rsp_tag  = q_tag[0];

endmodule

// File: tb/tb_vx_tb_mem_responder.sv
// Directed bench for vx_tb_mem_responder: reset state, read latency, credit
// backpressure with in-order return, aliasing, reset while reads are in flight,
// and write acknowledge (build dependent). Compile with VX_TB_MEM_WRITE_ACK_EN to
// match an RTL built with it.

module tb_vx_tb_mem_responder;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_rw;
    logic [25:0]  req_addr;
    logic [511:0] req_data;
    logic [7:0]   req_tag;
    logic         req_ready;
    logic         rsp_valid;
    logic [511:0] rsp_data;
    logic [7:0]   rsp_tag;
    logic         rsp_ready;
    logic [31:0]  wr_count;
    logic [31:0]  rd_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    vx_tb_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_ready (rsp_ready),
        .wr_count  (wr_count),
        .rd_count  (rd_count)
    );

    typedef struct {
        bit           rw;
        logic [25:0]  addr;
        logic [511:0] data;
        logic [7:0]   tag;
        logic [511:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input bit rw, input logic [25:0] addr, input logic [511:0] data,
                        input logic [7:0] tag);
        bit ok = 1'b0;
        req_rw = rw; req_addr = addr; req_data = data; req_tag = tag; req_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else chk("req_timeout", 512'd0, 512'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Called at a negedge; waits for and consumes one response.
    task automatic get_rsp(input string nm, input logic [7:0] tag, input logic [511:0] data);
        bit ok = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) begin
            chk({nm, "_tag"}, 512'(rsp_tag), 512'(tag));
            chk({nm, "_data"}, rsp_data, data);
            @(posedge clk);
        end else begin
            chk({nm, "_timeout"}, 512'd0, 512'd1);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wr(input logic [25:0] addr, input logic [511:0] data, input logic [7:0] tag);
        send(1'b1, addr, data, tag);
`ifdef VX_TB_MEM_WRITE_ACK_EN
        get_rsp("wr_ack", tag, 512'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] pa5, p5a, pdb;
        int acc;
        int seen;

        pa5 = {64{8'hA5}};
        p5a = {64{8'h5A}};
        pdb = {16{32'hDEADBEEF}};

        vecs[0] = '{1'b1, 26'h10,      pa5,     8'h00, '0};
        vecs[1] = '{1'b0, 26'h10,      '0,      8'h3C, pa5};
        vecs[2] = '{1'b1, 26'h7,       512'h11, 8'h00, '0};
        vecs[3] = '{1'b1, 26'h407,     512'h22, 8'h00, '0};
        vecs[4] = '{1'b0, 26'h7,       '0,      8'h01, 512'h22};
        vecs[5] = '{1'b0, 26'h407,     '0,      8'h02, 512'h22};
        vecs[6] = '{1'b1, 26'h3FF,     pdb,     8'h00, '0};
        vecs[7] = '{1'b0, 26'h3FF,     '0,      8'hFF, pdb};
        vecs[8] = '{1'b1, 26'h10,      p5a,     8'h00, '0};
        vecs[9] = '{1'b0, 26'h2000010, '0,      8'h80, p5a};

        // Reset held for 3 cycles.
        reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
        req_data = '0; req_tag = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 512'(req_ready), 512'd0);
        chk("rst_rsp_valid", 512'(rsp_valid), 512'd0);
        chk("rst_rsp_data", rsp_data, 512'd0);
        chk("rst_wr_count", 512'(wr_count), 512'd0);
        chk("rst_rd_count", 512'(rd_count), 512'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 512'(req_ready), 512'd1);

        // Write then read with exact latency: visible 4 cycles after accept cycle.
        wr(26'h10, pa5, 8'h00);
        req_rw = 1'b0; req_addr = 26'h10; req_tag = 8'h3C; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("lat_n3_valid", 512'(rsp_valid), 512'd0);
        @(negedge clk);
        chk("lat_n4_valid", 512'(rsp_valid), 512'd1);
        chk("lat_tag", 512'(rsp_tag), 512'(8'h3C));
        chk("lat_data", rsp_data, pa5);
        chk("lat_wr_count", 512'(wr_count), 512'd1);
        chk("lat_rd_count", 512'(rd_count), 512'd1);
        get_rsp("lat_pop", 8'h3C, pa5);
        chk("lat_empty", 512'(rsp_valid), 512'd0);

        // Credit backpressure: 4 of 6 reads accepted while rsp_ready is low.
        acc = 0;
        req_rw = 1'b0; req_addr = 26'h10; req_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            req_tag = 8'(acc + 1);
            if (req_ready) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("bp_accepted", 512'(acc), 512'd4);
        chk("bp_ready_low", 512'(req_ready), 512'd0);
        chk("bp_head_tag", 512'(rsp_tag), 512'd1);
        get_rsp("bp_r1", 8'd1, pa5);
        get_rsp("bp_r2", 8'd2, pa5);
        send(1'b0, 26'h10, '0, 8'd5);
        send(1'b0, 26'h10, '0, 8'd6);
        for (int t = 3; t <= 6; t++) get_rsp("bp_order", 8'(t), pa5);
        chk("bp_rd_count", 512'(rd_count), 512'd7);

        // Table: writes, reads, aliasing modulo 2^10.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rw) wr(vecs[i].addr, vecs[i].data, vecs[i].tag);
            else begin
                send(1'b0, vecs[i].addr, '0, vecs[i].tag);
                get_rsp($sformatf("vec%0d", i), vecs[i].tag, vecs[i].exp);
            end
        end

        // Reset with three reads in flight: no responses, store survives.
        send(1'b0, 26'h3FF, '0, 8'h21);
        send(1'b0, 26'h3FF, '0, 8'h22);
        send(1'b0, 26'h3FF, '0, 8'h23);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_valid", 512'(rsp_valid), 512'd0);
        chk("mid_rst_wr_count", 512'(wr_count), 512'd0);
        chk("mid_rst_rd_count", 512'(rd_count), 512'd0);
        seen = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        chk("mid_rst_no_rsp", 512'(seen), 512'd0);
        send(1'b0, 26'h3FF, '0, 8'h44);
        get_rsp("store_survives", 8'h44, pdb);
        chk("post_rst_rd_count", 512'(rd_count), 512'd1);

        // Write acknowledge depends on the build option.
`ifdef VX_TB_MEM_WRITE_ACK_EN
        send(1'b1, 26'h20, pa5, 8'h55);
        get_rsp("wr_ack_20", 8'h55, 512'd0);
`else
        send(1'b1, 26'h20, pa5, 8'h55);
        seen = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        chk("silent_write", 512'(seen), 512'd0);
        chk("silent_ready", 512'(req_ready), 512'd1);
`endif
        chk("final_wr_count", 512'(wr_count), 512'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
